wh_output_alloc: RTL and testbench

- Per-output-port wormhole switch allocator for the NoC router.
- Takes flit-level requests from N input buffers, selects one packet round-robin, and locks the output to that input from head to tail.
- Gates every flit transfer on downstream credits.
- One instance per router output port; the crossbar select is driven from grant_idx.

---
 rtl/noc_pkg.sv | 24 ++
 rtl/credit_cnt.sv | 65 ++++++
 rtl/wh_output_alloc.sv | 182 ++++++++++++++++++
 tb/tb_wh_output_alloc.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared NoC router types. These are the flit type encoding
//                carried beside each buffered flit, and the wormhole
//                allocator state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    typedef enum logic [1:0] {
        HEAD   = 2'b00,
        BODY   = 2'b01,
        TAIL   = 2'b10,
        SINGLE = 2'b11
    } flit_type_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_t;

endpackage
`default_nettype wire

// File: rtl/credit_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : credit_cnt
//  Description : Downstream credit counter. It resets to DEPTH, decrements
//                on a sent flit and increments on a returned credit. When
//                both happen in the same cycle the count does not change. A
//                return that would exceed DEPTH saturates the count and
//                raises ovf for that cycle.
//  Ports       : clk, rst (async, active-high)
//                dec   - a flit was forwarded this cycle
//                inc   - downstream returned one credit this cycle
//                cnt   - current credit count
//                avail - cnt != 0
//                ovf   - credit returned while already full (1-cycle pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
module credit_cnt #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          avail,
    output logic          ovf
);

    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        ovf       = 1'b0;
        if (inc && !dec) begin
            if (r_cnt == c_FULL) begin
                ovf = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end else if (dec && !inc) begin
            // The allocator never forwards at zero credits. The guard
            // stops a misbehaving user from wrapping the count.
            if (r_cnt != '0) begin
                w_cnt_nxt = r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= c_FULL;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign cnt   = r_cnt;
    assign avail = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/wh_output_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : wh_output_alloc
//  Description : Per-output-port wormhole switch allocator. In IDLE it picks
//                one HEAD/SINGLE requester round-robin. A HEAD locks the
//                output to that input until its TAIL has passed. Every
//                transfer is gated on downstream credits. A grant pops the
//                input buffer in the same cycle, so there is no ack.
//  Ports       : clk, rst (async, active-high)
//                req[N]         - input i has a flit for this output
//                flit_type[2N]  - type of input i's head flit, bits [2i+1:2i]
//                credit_in      - downstream freed one slot (pulse)
//                grant[N]       - one-hot pop/transfer strobe
//                grant_idx      - index of granted input, 0 when no grant
//                fwd            - a flit crosses the output this cycle
//                busy           - output locked to a packet
//                credits        - current downstream credit count
//                err            - sticky protocol error
//  Revision    : 1.0 - initial release
// ============================================================================
module wh_output_alloc
    import noc_pkg::*;
#(
    parameter int N     = 5,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [2*N-1:0]       flit_type,
    input  logic                 credit_in,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 fwd,
    output logic                 busy,
    output logic [CW-1:0]        credits,
    output logic                 err
);

    localparam int c_IW = $clog2(N);

    alloc_state_t    r_state;
    alloc_state_t    w_state_nxt;
    logic [c_IW-1:0] r_owner;
    logic [c_IW-1:0] w_owner_nxt;
    logic [c_IW-1:0] r_last;
    logic [c_IW-1:0] w_last_nxt;
    logic            r_err;
    logic            w_err_nxt;

    logic [N-1:0]    w_grant;
    logic [c_IW-1:0] w_idx;
    logic [c_IW-1:0] w_sel;
    logic [c_IW-1:0] w_pos;
    logic            w_found;
    int              w_cand;
    logic            w_avail;
    logic            w_ovf;

    flit_type_t      w_ft [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ft
            assign w_ft[gi] = flit_type_t'(flit_type[2*gi +: 2]);
        end
    endgenerate

    always_comb begin
        w_grant     = '0;
        w_idx       = '0;
        w_sel       = '0;
        w_pos       = '0;
        w_found     = 1'b0;
        w_cand      = 0;
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_err_nxt   = r_err | w_ovf;

        case (r_state)
            IDLE: begin
                // Round-robin scan starts just after the last winner and
                // wraps. The last winner itself is visited last.
                for (int k = 1; k <= N; k++) begin
                    w_cand = int'(r_last) + k;
                    if (w_cand >= N) begin
                        w_cand = w_cand - N;
                    end
                    w_pos = c_IW'(w_cand);
                    if (!w_found && req[w_pos] &&
                        (w_ft[w_pos] == HEAD || w_ft[w_pos] == SINGLE)) begin
                        w_found = 1'b1;
                        w_sel   = w_pos;
                    end
                end
                // A BODY or TAIL with no open packet is a protocol error.
                for (int i = 0; i < N; i++) begin
                    if (req[i] && (w_ft[i] == BODY || w_ft[i] == TAIL)) begin
                        w_err_nxt = 1'b1;
                    end
                end
                if (w_found && w_avail) begin
                    w_grant[w_sel] = 1'b1;
                    w_idx          = w_sel;
                    w_last_nxt     = w_sel;
                    if (w_ft[w_sel] == HEAD) begin
                        w_state_nxt = LOCKED;
                        w_owner_nxt = w_sel;
                    end
                end
            end

            LOCKED: begin
                // Only the owner matters here. When the owner drops req,
                // the lock is held with no timeout.
                if (req[r_owner]) begin
                    case (w_ft[r_owner])
                        BODY: begin
                            if (w_avail) begin
                                w_grant[r_owner] = 1'b1;
                                w_idx            = r_owner;
                            end
                        end
                        TAIL: begin
                            if (w_avail) begin
                                w_grant[r_owner] = 1'b1;
                                w_idx            = r_owner;
                                w_state_nxt      = IDLE;
                            end
                        end
                        default: begin
                            w_err_nxt = 1'b1;
                        end
                    endcase
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_last  <= c_IW'(N - 1);
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Outputs are forced quiet during reset. Otherwise a requester could
    // pop its buffer while the allocator is being cleared.
    assign grant     = rst ? '0 : w_grant;
    assign grant_idx = rst ? '0 : w_idx;
    assign fwd       = |grant;
    assign busy      = (r_state == LOCKED);
    assign err       = r_err;

    credit_cnt #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_credit_cnt (
        .clk   (clk),
        .rst   (rst),
        .dec   (fwd),
        .inc   (credit_in),
        .cnt   (credits),
        .avail (w_avail),
        .ovf   (w_ovf)
    );

endmodule
`default_nettype wire

// File: tb/tb_wh_output_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wh_output_alloc
//  Description : Self-checking bench for wh_output_alloc (N=5, DEPTH=4).
//                Each cycle's stimulus is driven together with its expected
//                outputs, which are hand-derived. A monitor pops them and
//                compares them shortly after the driving edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wh_output_alloc;
    import noc_pkg::*;

    localparam int N     = 5;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                 clk;
    logic                 rst;
    logic [N-1:0]         req;
    logic [2*N-1:0]       flit_type;
    logic                 credit_in;
    logic [N-1:0]         grant;
    logic [$clog2(N)-1:0] grant_idx;
    logic                 fwd;
    logic                 busy;
    logic [CW-1:0]        credits;
    logic                 err;

    wh_output_alloc #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .flit_type (flit_type),
        .credit_in (credit_in),
        .grant     (grant),
        .grant_idx (grant_idx),
        .fwd       (fwd),
        .busy      (busy),
        .credits   (credits),
        .err       (err)
    );

    typedef struct {
        string      tag;
        logic [4:0] g;
        int         idx;
        logic       b;
        int         cr;
        logic       e;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp;
    int   n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] ft5(input flit_type_t t4, input flit_type_t t3,
                                       input flit_type_t t2, input flit_type_t t1,
                                       input flit_type_t t0);
        return {t4, t3, t2, t1, t0};
    endfunction

    // Drive one cycle of stimulus and queue what the outputs must show.
    task automatic cyc(input string tag, input logic r, input logic [4:0] rq,
                       input logic [9:0] ft, input logic ci, input logic [4:0] eg,
                       input int eidx, input logic eb, input int ecr, input logic ee);
        exp_t x;
        @(negedge clk);
        rst       = r;
        req       = rq;
        flit_type = ft;
        credit_in = ci;
        x.tag = tag; x.g = eg; x.idx = eidx; x.b = eb; x.cr = ecr; x.e = ee;
        q_exp.push_back(x);
    endtask

    always @(negedge clk) begin
        exp_t x;
        #3;
        if (q_exp.size() > 0) begin
            x = q_exp.pop_front();
            check({x.tag, ".grant"},   32'(grant),     32'(x.g));
            check({x.tag, ".idx"},     32'(grant_idx), 32'(x.idx));
            check({x.tag, ".fwd"},     32'(fwd),       32'(|x.g));
            check({x.tag, ".busy"},    32'(busy),      32'(x.b));
            check({x.tag, ".credits"}, 32'(credits),   32'(x.cr));
            check({x.tag, ".err"},     32'(err),       32'(x.e));
        end
    end

    initial begin
        flit_type_t H, B, T, S;
        H = HEAD; B = BODY; T = TAIL; S = SINGLE;
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; req = '0; flit_type = '0; credit_in = 1'b0;
        repeat (2) @(negedge clk);

        // Reset: outputs quiet even with every input requesting.
        cyc("rst0", 1, 5'b11111, ft5(H,H,H,H,H), 0, 5'b00000, 0, 0, 4, 0);

        // Two SINGLE requesters alternate; credits drain 4->3->2->1.
        cyc("s1",   0, 5'b00101, ft5(S,S,S,S,S), 0, 5'b00001, 0, 0, 4, 0);
        cyc("s2",   0, 5'b00101, ft5(S,S,S,S,S), 0, 5'b00100, 2, 0, 3, 0);
        cyc("s3",   0, 5'b00101, ft5(S,S,S,S,S), 0, 5'b00001, 0, 0, 2, 0);
        cyc("cra",  0, 5'b00000, ft5(S,S,S,S,S), 1, 5'b00000, 0, 0, 1, 0);
        cyc("crb",  0, 5'b00000, ft5(S,S,S,S,S), 1, 5'b00000, 0, 0, 2, 0);
        cyc("crc",  0, 5'b00000, ft5(S,S,S,S,S), 1, 5'b00000, 0, 0, 3, 0);

        // Input 1 packet H,B,B,T locks out input 3's HEAD until after TAIL.
        cyc("wh",   0, 5'b01010, ft5(H,H,H,H,H), 0, 5'b00010, 1, 0, 4, 0);
        cyc("wb1",  0, 5'b01010, ft5(H,H,H,B,H), 1, 5'b00010, 1, 1, 3, 0);
        cyc("wb2",  0, 5'b01010, ft5(H,H,H,B,H), 1, 5'b00010, 1, 1, 3, 0);
        cyc("wt",   0, 5'b01010, ft5(H,H,H,T,H), 1, 5'b00010, 1, 1, 3, 0);
        cyc("w3h",  0, 5'b01000, ft5(H,H,H,H,H), 0, 5'b01000, 3, 0, 3, 0);
        // fwd and credit_in together at credits=2: no change.
        cyc("w3t",  0, 5'b01000, ft5(H,T,H,H,H), 1, 5'b01000, 3, 1, 2, 0);
        cyc("crd",  0, 5'b00000, ft5(H,H,H,H,H), 1, 5'b00000, 0, 0, 2, 0);
        cyc("cre",  0, 5'b00000, ft5(H,H,H,H,H), 1, 5'b00000, 0, 0, 3, 0);
        // Credit return at full: saturate and flag.
        cyc("sat",  0, 5'b00000, ft5(H,H,H,H,H), 1, 5'b00000, 0, 0, 4, 0);
        cyc("sate", 0, 5'b00000, ft5(H,H,H,H,H), 0, 5'b00000, 0, 0, 4, 1);

        // Input 0 six-flit packet against four credits.
        cyc("ph",   0, 5'b00001, ft5(H,H,H,H,H), 0, 5'b00001, 0, 0, 4, 1);
        cyc("pb1",  0, 5'b00001, ft5(H,H,H,H,B), 0, 5'b00001, 0, 1, 3, 1);
        cyc("pb2",  0, 5'b00001, ft5(H,H,H,H,B), 0, 5'b00001, 0, 1, 2, 1);
        cyc("pb3",  0, 5'b00001, ft5(H,H,H,H,B), 0, 5'b00001, 0, 1, 1, 1);
        cyc("pstl", 0, 5'b00001, ft5(H,H,H,H,B), 0, 5'b00000, 0, 1, 0, 1);
        cyc("pci",  0, 5'b00001, ft5(H,H,H,H,B), 1, 5'b00000, 0, 1, 0, 1);
        cyc("pb4",  0, 5'b00001, ft5(H,H,H,H,B), 0, 5'b00001, 0, 1, 1, 1);
        cyc("ptw",  0, 5'b00001, ft5(H,H,H,H,T), 1, 5'b00000, 0, 1, 0, 1);

        // Owner bubble: lock holds, input 4's HEAD is not served.
        cyc("bub1", 0, 5'b10000, ft5(H,H,H,H,T), 0, 5'b00000, 0, 1, 1, 1);
        cyc("bub2", 0, 5'b10000, ft5(H,H,H,H,T), 0, 5'b00000, 0, 1, 1, 1);
        cyc("bub3", 0, 5'b10000, ft5(H,H,H,H,T), 0, 5'b00000, 0, 1, 1, 1);
        cyc("pt",   0, 5'b10001, ft5(H,H,H,H,T), 0, 5'b00001, 0, 1, 1, 1);
        cyc("i4w",  0, 5'b10000, ft5(H,H,H,H,H), 1, 5'b00000, 0, 0, 0, 1);
        cyc("i4h",  0, 5'b10000, ft5(H,H,H,H,H), 0, 5'b10000, 4, 0, 1, 1);
        cyc("i4b",  0, 5'b10000, ft5(B,H,H,H,H), 1, 5'b00000, 0, 1, 0, 1);

        // Asynchronous reset while locked with credits=1.
        cyc("rstl", 1, 5'b10000, ft5(B,H,H,H,H), 0, 5'b00000, 0, 0, 4, 0);
        cyc("rel",  0, 5'b11111, ft5(H,H,H,H,H), 0, 5'b00001, 0, 0, 4, 0);
        cyc("lb",   0, 5'b11111, ft5(H,H,H,H,B), 0, 5'b00001, 0, 1, 3, 0);
        // Owner presents HEAD while locked: no grant, error.
        cyc("lhd",  0, 5'b11111, ft5(H,H,H,H,H), 0, 5'b00000, 0, 1, 2, 0);
        cyc("lhe",  0, 5'b00000, ft5(H,H,H,H,H), 0, 5'b00000, 0, 1, 2, 1);

        // BODY request in IDLE: ignored, error.
        cyc("rst2", 1, 5'b00000, ft5(H,H,H,H,H), 0, 5'b00000, 0, 0, 4, 0);
        cyc("ibd",  0, 5'b00100, ft5(H,H,B,H,H), 0, 5'b00000, 0, 0, 4, 0);
        cyc("ibe",  0, 5'b00000, ft5(H,H,H,H,H), 0, 5'b00000, 0, 0, 4, 1);

        @(negedge clk);
        #5;
        check("drain", 32'(q_exp.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
